lut_layer_sequencer: RTL and testbench
======================================

# lut_layer_sequencer

Time-multiplexed evaluator for one LUT-neuron layer. Instead of instantiating one combinational truth-table ROM per neuron, all neuron tables share a single synchronous-read table memory. The block accepts a quantised feature vector, steps through every neuron, gathers each neuron's fan-in bits through a programmable connectivity table, looks up its output code, and returns the assembled output vector. It sits between a layer's input register and the next layer, and is configured over a simple write port while idle.

## Interface
- N_NEURONS, 8: neurons evaluated per input vector.
- N_INPUTS, 16: input features.
- FANIN, 3: inputs per neuron.
- IN_BITS, 2: bits per input feature.
- OUT_BITS, 2: bits per neuron output.
- Derived: AW = FANIN*IN_BITS (6); NW = clog2(N_NEURONS); IW = clog2(N_INPUTS); CW = clog2(N_NEURONS*FANIN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept an input vector.
- in_data  in  N_INPUTS*IN_BITS  feature f at [f*IN_BITS +: IN_BITS].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  N_NEURONS*OUT_BITS  neuron n at [n*OUT_BITS +: OUT_BITS].
- tt_we  in  1  truth-table write strobe.
- tt_addr  in  NW+AW  {neuron, lut address}.
- tt_wdata  in  OUT_BITS  table entry.
- conn_we  in  1  connectivity write strobe.
- conn_addr  in  CW  neuron*FANIN + slot.
- conn_wdata  in  IW  feature index feeding that slot.
- busy  out  1  high whenever the state is not IDLE.
- cfg_err  out  1  one-cycle pulse when a config write is dropped.

## Operation
- Four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into an input register, clear counter n, and go to RUN.
- RUN:
  - For each cycle with neuron index n, form addr = {n, g}.
  - Bits g[j*IN_BITS +: IN_BITS] hold the latched feature conn[n*FANIN+j], for j = 0..FANIN-1.
  - Issue a synchronous read of addr, then increment n.
  - After issuing n = N_NEURONS-1, go to DRAIN.
- Result capture: the read result for neuron n is written into out slot n on the following cycle. This happens in RUN for n < N_NEURONS-1 and in DRAIN for the last neuron.
- DRAIN: one cycle, then go to DONE.
- DONE:
  - out_valid=1; out_data is stable and frozen.
  - On out_ready, go to IDLE.
- Config writes:
  - Applied only in IDLE.
  - In any other state the write is dropped, the table is unchanged, and cfg_err pulses the next cycle.
  - tt_we and conn_we in the same cycle are both applied.
- A connectivity value ≥ N_INPUTS selects feature 0.
- Widths: n counter is NW bits, compared against N_NEURONS-1 (it does not wrap to terminate); no arithmetic overflow is possible elsewhere.

## Timing
- Handshake:
  - An input is accepted on the edge where in_valid & in_ready.
  - out_valid rises exactly N_NEURONS+2 cycles after that edge (10 at defaults).
  - in_ready and out_valid are never high together.
- Throughput: one vector per N_NEURONS+3 cycles when out_ready is held high.
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, cfg_err=0.
  - Connectivity entries are 0.
  - Truth-table memory is not reset; it must be loaded before use.
- Reset asserted mid-RUN or in DONE: immediately returns to IDLE with out_data cleared; the vector is lost.
- out_ready high while not in DONE is ignored.
- in_valid held high during busy: the vector is not accepted until the block returns to IDLE.

## Structure
- Shared package lut_layer_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default parameter constants;
  - the address-packing function {neuron, gathered bits}.
- One sub-module, lut_table_ram: single-port write, synchronous read, depth N_NEURONS*2^AW, width OUT_BITS, distributed-RAM style.
- The FSM, input register, connectivity register file and gather mux live in the top level.

## Test plan
- Reset then idle:
  - Check in_ready=1, out_valid=0, out_data=0.
  - Pulse rst mid-RUN: back to IDLE next edge, out_data=0.
- Identity layer (tt entry = addr[1:0] for all neurons):
  - conn[n*3+0]=n; in_data with feature f = f%4.
  - out slot n = n%4; out_valid exactly 10 cycles after accept.
- Constant tables:
  - neuron n table filled with n%4, input random.
  - out_data = 16'hE4E4.
- Gather ordering:
  - neuron 0: conn = {5,9,2} for slots 0,1,2; features 5=1, 9=2, 2=3; tt[0][6'b111001]=2'b11, all others 0.
  - slot 0 = 3.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in DONE: out_data stable, in_ready=0, second in_valid not accepted.
  - Release: IDLE next edge, then second vector accepted.
- Config while busy:
  - tt_we during RUN: cfg_err pulses once, table unchanged.
  - Rerun: same result as before.

Source files
------------

// File: rtl/lut_layer_pkg.sv
// Shared definitions for the LUT-neuron layer sequencer.
// Holds the layer geometry, the controller state encoding and the helper that
// packs a neuron index and its gathered fan-in bits into a table address.
package lut_layer_pkg;

    localparam int N_NEURONS = 8;
    localparam int N_INPUTS  = 16;
    localparam int FANIN     = 3;
    localparam int IN_BITS   = 2;
    localparam int OUT_BITS  = 2;

    localparam int AW = FANIN * IN_BITS;              // per-neuron LUT address width
    localparam int NW = $clog2(N_NEURONS);            // neuron index width
    localparam int IW = $clog2(N_INPUTS);             // feature index width
    localparam int CW = $clog2(N_NEURONS * FANIN);    // connectivity address width
    localparam int TW = NW + AW;                      // shared table address width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Each neuron owns a contiguous 2^AW slice of the shared table.
    function automatic logic [TW-1:0] pack_addr(input logic [NW-1:0] neuron,
                                                input logic [AW-1:0] gathered);
        return {neuron, gathered};
    endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// Data and configuration bus of the LUT-neuron layer sequencer.
//   in_valid/in_ready/in_data      : input feature vector handshake
//   out_valid/out_ready/out_data   : result vector handshake
//   tt_we/tt_addr/tt_wdata         : truth-table write port {neuron, lut address}
//   conn_we/conn_addr/conn_wdata   : connectivity write port (neuron*FANIN + slot)
// master drives vectors and configuration, slave is the sequencer.
interface lut_layer_sequencer_if;
    import lut_layer_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [N_INPUTS*IN_BITS-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_NEURONS*OUT_BITS-1:0] out_data;
    logic                          tt_we;
    logic [TW-1:0]                 tt_addr;
    logic [OUT_BITS-1:0]           tt_wdata;
    logic                          conn_we;
    logic [CW-1:0]                 conn_addr;
    logic [IW-1:0]                 conn_wdata;

    modport master (
        output in_valid, in_data, out_ready,
        output tt_we, tt_addr, tt_wdata, conn_we, conn_addr, conn_wdata,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        input  tt_we, tt_addr, tt_wdata, conn_we, conn_addr, conn_wdata,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/lut_table_ram.sv
// Shared truth-table memory for all neurons of the layer.
// Single write port, registered (synchronous) read, depth N_NEURONS*2^AW,
// width OUT_BITS, written in a style that maps to distributed RAM.
//   clk     : clock
//   we_i    : write strobe
//   waddr_i : write address {neuron, lut address}
//   wdata_i : write data
//   raddr_i : read address, data appears on rdata_o after the next edge
//   rdata_o : registered read data
module lut_table_ram
    import lut_layer_pkg::*;
(
    input  logic                clk,
    input  logic                we_i,
    input  logic [TW-1:0]       waddr_i,
    input  logic [OUT_BITS-1:0] wdata_i,
    input  logic [TW-1:0]       raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);

    logic [OUT_BITS-1:0] mem_q [N_NEURONS * (1 << AW)];
    logic [OUT_BITS-1:0] rdata_q;

    // NOTE: the array has no reset branch; a reset loop over every word would
    // stop it mapping onto RAM primitives, so contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one LUT-neuron layer.
// Latches a feature vector, then evaluates one neuron per cycle: the neuron's
// fan-in features are gathered through the connectivity table, looked up in
// the shared truth table, and the result lands in that neuron's output slot.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : vector handshakes and configuration ports (slave side)
//   busy_o    : high whenever the controller is not IDLE
//   cfg_err_o : one-cycle pulse after a configuration write was dropped
module lut_layer_sequencer
    import lut_layer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    lut_layer_sequencer_if.slave bus,
    output logic                 busy_o,
    output logic                 cfg_err_o
);

    state_e                        state_q, state_d;
    logic [NW-1:0]                 n_q, n_d;
    logic [IN_BITS-1:0]            feat_q [N_INPUTS];
    logic [IW-1:0]                 conn_q [N_NEURONS*FANIN];
    logic [N_NEURONS*OUT_BITS-1:0] out_q;
    logic                          cap_v_q;   // a read was issued last cycle
    logic [NW-1:0]                 cap_n_q;   // neuron that read belongs to
    logic                          cfg_err_q;
    logic [AW-1:0]                 gathered;
    logic [OUT_BITS-1:0]           rd_data;
    logic                          idle;

    assign idle = (state_q == IDLE);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    n_d     = '0;
                end
            end
            RUN: begin
                n_d = n_q + 1'b1;
                if (n_q == NW'(N_NEURONS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gather mux: slot j of neuron n_q reads the feature named by its
    // connectivity entry; an out-of-range index falls back to feature 0.
    always_comb begin
        logic [IW-1:0] fidx;
        gathered = '0;
        fidx     = '0;
        for (int j = 0; j < FANIN; j++) begin
            fidx = conn_q[CW'(int'(n_q) * FANIN + j)];
            if (int'(fidx) < N_INPUTS) begin
                gathered[j*IN_BITS +: IN_BITS] = feat_q[fidx];
            end else begin
                gathered[j*IN_BITS +: IN_BITS] = feat_q[0];
            end
        end
    end

    lut_table_ram u_table (
        .clk     (clk),
        .we_i    (bus.tt_we && idle),
        .waddr_i (bus.tt_addr),
        .wdata_i (bus.tt_wdata),
        .raddr_i (pack_addr(n_q, gathered)),
        .rdata_o (rd_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cap_v_q   <= 1'b0;
            cap_n_q   <= '0;
            out_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cap_v_q   <= (state_q == RUN);
            cap_n_q   <= n_q;
            cfg_err_q <= !idle && (bus.tt_we || bus.conn_we);
            // The last neuron's result is captured during DRAIN.
            if (cap_v_q) begin
                out_q[int'(cap_n_q)*OUT_BITS +: OUT_BITS] <= rd_data;
            end
        end
    end

    // Input vector register and connectivity register file; both only change
    // while IDLE, so they are stable for the whole evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < N_INPUTS; f++) feat_q[f] <= '0;
            for (int c = 0; c < N_NEURONS*FANIN; c++) conn_q[c] <= '0;
        end else if (idle) begin
            if (bus.in_valid) begin
                for (int f = 0; f < N_INPUTS; f++) begin
                    feat_q[f] <= bus.in_data[f*IN_BITS +: IN_BITS];
                end
            end
            if (bus.conn_we && int'(bus.conn_addr) < N_NEURONS*FANIN) begin
                conn_q[bus.conn_addr] <= bus.conn_wdata;
            end
        end
    end

    assign bus.in_ready  = idle;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;
    assign busy_o        = !idle;
    assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: identity, constant and gather-order
// tables, backpressure, dropped config writes and reset during a run.
module tb_lut_layer_sequencer;
    import lut_layer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic cfg_err;
    int   n_vec = 0;
    int   n_err = 0;

    lut_layer_sequencer_if bus ();

    lut_layer_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy_o    (busy),
        .cfg_err_o (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: entry = lut address[1:0]; mode 1: entry = neuron % 4; mode 2: all zero
    task automatic fill_tt(input int mode);
        for (int n = 0; n < N_NEURONS; n++) begin
            for (int a = 0; a < (1 << AW); a++) begin
                @(negedge clk);
                bus.tt_we    = 1'b1;
                bus.tt_addr  = TW'(n * (1 << AW) + a);
                bus.tt_wdata = (mode == 0) ? OUT_BITS'(a % 4) :
                               (mode == 1) ? OUT_BITS'(n % 4) : '0;
            end
        end
        @(negedge clk);
        bus.tt_we = 1'b0;
    endtask

    task automatic tt_write(input int addr, input int data);
        @(negedge clk);
        bus.tt_we = 1'b1; bus.tt_addr = TW'(addr); bus.tt_wdata = OUT_BITS'(data);
        @(negedge clk);
        bus.tt_we = 1'b0;
    endtask

    task automatic conn_write(input int addr, input int data);
        @(negedge clk);
        bus.conn_we = 1'b1; bus.conn_addr = CW'(addr); bus.conn_wdata = IW'(data);
        @(negedge clk);
        bus.conn_we = 1'b0;
    endtask

    // Presents a vector while IDLE; returns at the first negedge after acceptance.
    task automatic send(input logic [31:0] data);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles after acceptance (the cycle following the accept edge is 1)
    // until out_valid; optionally fires a truth-table write in cycle 3.
    task automatic wait_done(input bit poke);
        int cyc = 1;
        while (!bus.out_valid && cyc < 40) begin
            if (poke) begin
                if (cyc == 3) begin
                    check("busy_in_run", busy, 1);
                    bus.tt_we = 1'b1; bus.tt_addr = TW'(3); bus.tt_wdata = '0;
                end
                if (cyc == 4) begin
                    bus.tt_we = 1'b0;
                    check("cfg_err_pulse", cfg_err, 1);
                end
                if (cyc == 5) check("cfg_err_clear", cfg_err, 0);
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, N_NEURONS + 2);
    endtask

    task automatic finish_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("back_idle", bus.in_ready, 1);
    endtask

    task automatic run_vector(input string tag, input logic [31:0] data,
                              input logic [15:0] exp, input bit poke);
        send(data);
        wait_done(poke);
        check(tag, bus.out_data, exp);
        finish_out();
    endtask

    initial begin
        logic [31:0] d;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        bus.tt_we = 0; bus.tt_addr = '0; bus.tt_wdata = '0;
        bus.conn_we = 0; bus.conn_addr = '0; bus.conn_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);

        // Identity tables, slot 0 of neuron n fed by feature n (feature f = f%4).
        fill_tt(0);
        for (int n = 0; n < N_NEURONS; n++) conn_write(n * FANIN, n);
        run_vector("identity", 32'hE4E4E4E4, 16'hE4E4, 0);

        // Backpressure: result held, second vector waits until IDLE.
        send(32'hE4E4E4E4);
        wait_done(0);
        check("bp_first", bus.out_data, 16'hE4E4);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1B1B1B1B;   // feature f = 3 - f%4
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_stable", bus.out_data, 16'hE4E4);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_idle", bus.in_ready, 1);
        check("bp_release_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_second_accepted", busy, 1);
        wait_done(0);
        check("bp_second", bus.out_data, 16'h1B1B);
        finish_out();

        // Reversed feeding: neuron n reads feature 15-n.
        for (int n = 0; n < N_NEURONS; n++) conn_write(n * FANIN, 15 - n);
        run_vector("reversed", 32'hE4E4E4E4, 16'h1B1B, 0);

        // Config write during RUN is dropped (would zero neuron 0's hit entry).
        run_vector("cfg_busy_run", 32'hE4E4E4E4, 16'h1B1B, 1);
        run_vector("cfg_busy_rerun", 32'hE4E4E4E4, 16'h1B1B, 0);

        // Gather ordering: slots {5,9,2} with features 5=1, 9=2, 2=3 -> 6'b111001.
        fill_tt(2);
        tt_write(6'b111001, 3);
        conn_write(0, 5); conn_write(1, 9); conn_write(2, 2);
        d = '0; d[11:10] = 2'd1; d[19:18] = 2'd2; d[5:4] = 2'd3;
        run_vector("gather_order", d, 16'h0003, 0);
        conn_write(0, 9); conn_write(1, 5);   // swapped slots -> 6'b110110, entry 0
        run_vector("gather_swapped", d, 16'h0000, 0);

        // Constant tables: output independent of input.
        fill_tt(1);
        run_vector("const_a", $urandom(), 16'hE4E4, 0);
        run_vector("const_b", $urandom(), 16'hE4E4, 0);

        // Reset mid-RUN clears the result and returns to IDLE.
        send($urandom());
        repeat (2) @(negedge clk);
        check("mid_run_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        rst = 1'b0;

        // Truth table survives reset; then reset while in DONE.
        send($urandom());
        wait_done(0);
        check("post_rst_const", bus.out_data, 16'hE4E4);
        rst = 1'b1;
        @(negedge clk);
        check("done_rst_valid", bus.out_valid, 0);
        check("done_rst_out_data", bus.out_data, 0);
        check("done_rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
